// File: rtl/s3_writeback.sv
// Writeback stage of the 3-stage RV32I core: S2->S3 register, load extraction,
// register-file write port, S3->S2 forwarding flags, tohost CSR and counters.
module s3_writeback #(
  parameter logic [31:0] NOP_INSN        = 32'h0000_0013,
  parameter logic [11:0] CSR_TOHOST_ADDR = 12'h51E
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        s2_valid,
  input  logic [31:0] instruction_s2,
  input  logic [31:0] alu_result_s2,
  input  logic [31:0] pc_s2,
  input  logic [31:0] dmem_rdata,
  input  logic [31:0] bios_rdata,
  input  logic [31:0] io_rdata,
  output logic [31:0] instruction_s3,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        fwd_rs1,
  output logic        fwd_rs2,
  output logic [31:0] csr_tohost,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
);
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_ARI_R  = 7'b0110011;
  localparam logic [6:0] OPC_ARI_I  = 7'b0010011;
  localparam logic [6:0] OPC_CSR    = 7'b1110011;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] alu;
    logic [31:0] pc;
    logic        vld;
  } s3_reg_t;

  s3_reg_t     s3_q;
  logic [31:0] cycle_q, instret_q, tohost_q;

  always_ff @(posedge clk) begin
    if (rst)
      s3_q <= '{insn: NOP_INSN, alu: 32'h0, pc: 32'h0, vld: 1'b0};
    else if (!stall) begin
      if (!s2_valid)
        s3_q <= '{insn: NOP_INSN, alu: 32'h0, pc: 32'h0, vld: 1'b0};
      else
        s3_q <= '{insn: instruction_s2, alu: alu_result_s2, pc: pc_s2, vld: 1'b1};
    end
  end

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic        retire;
  assign opc    = s3_q.insn[6:0];
  assign f3     = s3_q.insn[14:12];
  assign rd     = s3_q.insn[11:7];
  assign retire = s3_q.vld && !stall;

  logic [31:0] rdata, shifted, ld_data;
  logic [15:0] ld_half;
  logic [7:0]  ld_byte;

  always_comb begin
    rdata = 32'h0;
    casez (s3_q.alu[31:28])
      4'b00?1: rdata = dmem_rdata;
      4'b0100: rdata = bios_rdata;
      4'b1000: rdata = io_rdata;
      default: rdata = 32'h0;
    endcase
  end

  assign shifted = rdata >> {s3_q.alu[1:0], 3'b000};
  assign ld_byte = shifted[7:0];
  assign ld_half = s3_q.alu[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    ld_data = rdata;
    case (f3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = rdata;
    endcase
  end

  logic writes_rd;
  always_comb begin
    writes_rd = 1'b0;
    rf_wdata  = s3_q.alu;
    case (opc)
      OPC_LOAD:                 begin writes_rd = 1'b1; rf_wdata = ld_data; end
      OPC_JAL, OPC_JALR:        begin writes_rd = 1'b1; rf_wdata = s3_q.pc + 32'd4; end
      OPC_LUI, OPC_AUIPC,
      OPC_ARI_R, OPC_ARI_I:     writes_rd = 1'b1;
      default:                  writes_rd = 1'b0;
    endcase
  end

  assign rf_we          = s3_q.vld && writes_rd && (rd != 5'd0);
  assign rf_waddr       = rd;
  assign fwd_rs1        = rf_we && (rd == instruction_s2[19:15]);
  assign fwd_rs2        = rf_we && (rd == instruction_s2[24:20]);
  assign instruction_s3 = s3_q.insn;

  // csrw and csrwi only; other CSR forms and addresses leave tohost alone.
  logic tohost_wr;
  assign tohost_wr = retire && (opc == OPC_CSR) && (f3 == 3'b001 || f3 == 3'b101)
                     && (s3_q.insn[31:20] == CSR_TOHOST_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= 32'h0;
      instret_q <= 32'h0;
      tohost_q  <= 32'h0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (retire)    instret_q <= instret_q + 32'd1;
      if (tohost_wr) tohost_q  <= s3_q.alu;
    end
  end

  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;
  assign csr_tohost    = tohost_q;
endmodule

// File: tb/tb_s3_writeback.sv
// Directed bench for s3_writeback: reset, loads, writeback/forwarding, CSR, stall, wrap.
module tb_s3_writeback;
  logic        clk = 1'b0;
  logic        rst, stall, s2_valid;
  logic [31:0] instruction_s2, alu_result_s2, pc_s2;
  logic [31:0] dmem_rdata, bios_rdata, io_rdata;
  logic [31:0] instruction_s3, rf_wdata, csr_tohost, cycle_count, instret_count;
  logic        rf_we, fwd_rs1, fwd_rs2;
  logic [4:0]  rf_waddr;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] ADDI_X5  = 32'h0070_0293;
  localparam logic [31:0] ADD_X6   = 32'h0052_8333;
  localparam logic [31:0] ADDI_X0  = 32'h0070_0013;
  localparam logic [31:0] LB_X1    = 32'h0001_0083;
  localparam logic [31:0] LHU_X1   = 32'h0001_5083;
  localparam logic [31:0] LW_X1    = 32'h0001_2083;
  localparam logic [31:0] JAL_X1   = 32'h0000_00EF;
  localparam logic [31:0] CSRWI_1E = 32'h51E0_D073;
  localparam logic [31:0] CSRW_1F  = 32'h51F0_9073;

  s3_writeback dut (
    .clk(clk), .rst(rst), .stall(stall), .s2_valid(s2_valid),
    .instruction_s2(instruction_s2), .alu_result_s2(alu_result_s2), .pc_s2(pc_s2),
    .dmem_rdata(dmem_rdata), .bios_rdata(bios_rdata), .io_rdata(io_rdata),
    .instruction_s3(instruction_s3), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .csr_tohost(csr_tohost), .cycle_count(cycle_count), .instret_count(instret_count)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] insn, input logic [31:0] alu, input logic [31:0] pc);
    s2_valid = 1'b1; instruction_s2 = insn; alu_result_s2 = alu; pc_s2 = pc;
    tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; s2_valid = 1'b0;
    instruction_s2 = 32'h0; alu_result_s2 = 32'h0; pc_s2 = 32'h0;
    dmem_rdata = 32'h0; bios_rdata = 32'h0; io_rdata = 32'h0;
    tick(); tick();
    chk("reset_insn", instruction_s3, NOP);
    chk("reset_rf_we", {31'h0, rf_we}, 32'h0);
    chk("reset_fwd", {30'h0, fwd_rs1, fwd_rs2}, 32'h0);
    chk("reset_cycle", cycle_count, 32'h0);
    chk("reset_instret", instret_count, 32'h0);
    chk("reset_tohost", csr_tohost, 32'h0);
    rst = 1'b0;
    tick();
    chk("cycle_after_reset", cycle_count, 32'h1);
    chk("instret_after_reset", instret_count, 32'h0);
  endtask

  task automatic test_load_extract();
    dmem_rdata = 32'h80FF_1234; bios_rdata = 32'hDEAD_BEEF; io_rdata = 32'h5555_AAAA;
    issue(LB_X1, 32'h1000_0003, 32'h200);
    chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);
    chk("lb_we", {31'h0, rf_we}, 32'h1);
    issue(LHU_X1, 32'h1000_0003, 32'h204);
    chk("lhu_wdata", rf_wdata, 32'h0000_80FF);
    issue(LW_X1, 32'h4000_0002, 32'h208);
    chk("lw_bios_wdata", rf_wdata, 32'hDEAD_BEEF);
    issue(LW_X1, 32'h8000_0000, 32'h20C);
    chk("lw_io_wdata", rf_wdata, 32'h5555_AAAA);
    issue(LW_X1, 32'hC000_0000, 32'h210);
    chk("lw_unmapped_wdata", rf_wdata, 32'h0);
  endtask

  task automatic test_writeback_forward();
    issue(ADDI_X5, 32'h7, 32'h100);
    instruction_s2 = ADD_X6; s2_valid = 1'b0;
    #1;
    chk("addi_we", {31'h0, rf_we}, 32'h1);
    chk("addi_waddr", {27'h0, rf_waddr}, 32'd5);
    chk("addi_wdata", rf_wdata, 32'h7);
    chk("addi_fwd", {30'h0, fwd_rs1, fwd_rs2}, 32'h3);
    issue(ADDI_X0, 32'h7, 32'h104);
    instruction_s2 = 32'h0000_0033;
    #1;
    chk("x0_we", {31'h0, rf_we}, 32'h0);
    chk("x0_fwd", {30'h0, fwd_rs1, fwd_rs2}, 32'h0);
    issue(JAL_X1, 32'h55, 32'h100);
    chk("jal_wdata", rf_wdata, 32'h104);
    chk("jal_we", {31'h0, rf_we}, 32'h1);
  endtask

  task automatic test_csr();
    issue(CSRWI_1E, 32'h1, 32'h300);
    chk("csrwi_we", {31'h0, rf_we}, 32'h0);
    chk("tohost_before", csr_tohost, 32'h0);
    issue(CSRW_1F, 32'h99, 32'h304);
    chk("tohost_written", csr_tohost, 32'h1);
    s2_valid = 1'b0;
    tick();
    chk("tohost_other_addr", csr_tohost, 32'h1);
  endtask

  task automatic test_stall_bubble();
    logic [31:0] c0, i0;
    issue(ADDI_X5, 32'h7, 32'h400);
    c0 = cycle_count; i0 = instret_count;
    stall = 1'b1; instruction_s2 = ADD_X6; alu_result_s2 = 32'h1234; s2_valid = 1'b1;
    tick(); tick(); tick();
    chk("stall_insn_held", instruction_s3, ADDI_X5);
    chk("stall_wdata_held", rf_wdata, 32'h7);
    chk("stall_rf_we", {31'h0, rf_we}, 32'h1);
    chk("stall_instret", instret_count, i0);
    chk("stall_cycle", cycle_count, c0 + 32'd3);
    stall = 1'b0; s2_valid = 1'b0;
    tick();
    chk("bubble_insn", instruction_s3, NOP);
    chk("bubble_retire_prev", instret_count, i0 + 32'd1);
    chk("bubble_we", {31'h0, rf_we}, 32'h0);
    tick();
    chk("bubble_no_retire", instret_count, i0 + 32'd1);
  endtask

  task automatic test_reset_mid_stall();
    issue(CSRWI_1E, 32'h2, 32'h500);
    stall = 1'b1; rst = 1'b1;
    tick();
    chk("rst_stall_insn", instruction_s3, NOP);
    chk("rst_stall_cycle", cycle_count, 32'h0);
    chk("rst_stall_instret", instret_count, 32'h0);
    chk("rst_stall_tohost", csr_tohost, 32'h0);
    rst = 1'b0; stall = 1'b0;
  endtask

  task automatic test_wrap();
    issue(ADDI_X5, 32'h7, 32'h600);
    force dut.cycle_q = 32'hFFFF_FFFF;
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_q;
    release dut.instret_q;
    s2_valid = 1'b0;
    tick();
    chk("wrap_cycle", cycle_count, 32'h0);
    chk("wrap_instret", instret_count, 32'h0);
  endtask

  initial begin
    test_reset();
    test_load_extract();
    test_writeback_forward();
    test_csr();
    test_stall_bubble();
    test_reset_mid_stall();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/s3_writeback.md
Name: s3_writeback

Overview:
- Third (writeback) stage of the 3-stage RV32I core; sits directly downstream of the stage-2 execute control/datapath.
- Owns the S2→S3 pipeline register and load-data extraction/extension.
- Generates the register-file write port and S3→S2 forwarding flags.
- Holds the tohost CSR and the cycle / retired-instruction counters.

Parameters:
- NOP_INSN, 32'h0000_0013, instruction loaded into S3 on reset or bubble (addi x0,x0,0).
- CSR_TOHOST_ADDR, 12'h51E, CSR address written by csrw/csrwi.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold S3 register; no retire this cycle
- s2_valid  in  1  S2 instruction is real (0 = bubble after redirect)
- instruction_s2  in  32  S2 instruction word
- alu_result_s2  in  32  S2 ALU result (address / value / CSR data)
- pc_s2  in  32  S2 PC
- dmem_rdata  in  32  DMEM sync-read data, valid in S3 cycle
- bios_rdata  in  32  BIOS sync-read data, valid in S3 cycle
- io_rdata  in  32  MMIO read data, valid in S3 cycle
- instruction_s3  out  32  registered S3 instruction
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  rd of S3
- rf_wdata  out  32  writeback value (also forwarding data)
- fwd_rs1  out  1  S3 rd matches instruction_s2 rs1
- fwd_rs2  out  1  S3 rd matches instruction_s2 rs2
- csr_tohost  out  32  tohost CSR
- cycle_count  out  32  free-running cycle counter
- instret_count  out  32  retired-instruction counter

Behaviour:
- S3 register (instruction_s3, alu_s3, pc_s3, valid_s3) updates on posedge clk:
  - rst: NOP_INSN / 0 / 0 / 0.
  - else stall: hold all values.
  - else s2_valid=0: NOP_INSN, valid_s3=0.
  - else: capture S2 values, valid_s3=1.
- Latency: one cycle from S2 to S3. All rf_*/fwd_* outputs are combinational from the S3 register, the read-data inputs and instruction_s2.
- Read-source select on alu_s3[31:28]:
  - 4'b00x1 → dmem_rdata
  - 4'b0100 → bios_rdata
  - 4'b1000 → io_rdata
  - any other value → 32'h0
- Load extraction, offset alu_s3[1:0]:
  - LW: whole word; low address bits ignored.
  - LH/LHU: half selected by bit[1]; bit[0] ignored.
  - LB/LBU: byte selected by [1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Undefined func3: treat as LW.
- rf_wdata by S3 opcode:
  - LOAD → extracted data
  - JAL/JALR → pc_s3+4 (mod 2^32)
  - all other opcodes → alu_s3
- rf_we=1 only when all hold: valid_s3; opcode ∈ {LUI, AUIPC, JAL, JALR, LOAD, ARI_RTYPE, ARI_ITYPE}; rd≠0.
- CSR instructions never write the register file. rf_we is independent of stall; the RF write repeats with the same value while stalled.
- fwd_rs1 = rf_we && rd_s3 == instruction_s2[19:15].
- fwd_rs2 = rf_we && rd_s3 == instruction_s2[24:20].
- fwd_* are raised regardless of S2 opcode; S2 ignores them for unused operands.
- Retire condition: valid_s3 && !stall.
- csr_tohost:
  - Reset 0.
  - On retire of an OPC_CSR instruction with func3 ∈ {001, 101} and imm[31:20]==CSR_TOHOST_ADDR: csr_tohost <= alu_s3.
  - Other CSR addresses: no effect.
- cycle_count: reset 0; +1 every non-reset cycle, including stalls; wraps FFFF_FFFF→0.
- instret_count: reset 0; +1 on each retire; wraps.
- Reset mid-stall: rst wins; all state cleared the same cycle.

Test Plan:
- Reset: rst high 2 cycles → instruction_s3=0x00000013, rf_we=0, fwd_*=0, all counters and csr_tohost 0; next cycle cycle_count=1.
- Load extract: LB, alu=0x1000_0003, dmem_rdata=0x80FF_1234 → rf_wdata=0xFFFF_FF80. LHU same address → 0x0000_80FF. LW alu=0x4000_0002, bios_rdata=0xDEAD_BEEF → 0xDEAD_BEEF.
- Writeback/forward: addi x5 in S3 with alu=7, S2 add x6,x5,x5 → rf_we=1, waddr=5, wdata=7, fwd_rs1=fwd_rs2=1. Same with rd=x0 → rf_we=0, fwd_*=0. JAL pc=0x100 → wdata=0x104.
- CSR: csrwi 0x51E with alu=1 retires → csr_tohost=1 next cycle, rf_we=0. csrw 0x51F → csr_tohost unchanged.
- Stall/bubble: stall 3 cycles with a valid S3 → S3 held, instret_count unchanged, cycle_count +3. Then s2_valid=0 → S3=NOP, instret does not increment on its retire.
- Wrap: force counters to 0xFFFF_FFFF, one retire → both read 0.
